// File: rtl/sampler_pkg.sv
// Shared constants and FSM state type for the rejection sampler.
package sampler_pkg;

    localparam int unsigned Q_DEF     = 8380417;
    localparam int unsigned SBITS_DEF = 23;
    localparam int unsigned DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/sample_fifo.sv
// Power-of-two circular buffer for accepted samples; head is zero while empty.
module sample_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end

    assign rdata = empty ? '0 : mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/rand_reject_sampler.sv
// Batch rejection sampler: pulls raw words, keeps candidates below Q, buffers them in order.
module rand_reject_sampler
    import sampler_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned Q     = Q_DEF,
    parameter int unsigned SBITS = SBITS_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [15:0]        num_samples,
    output logic               rand_en,
    input  logic signed [31:0] rand_num,
    output logic               smp_valid,
    input  logic               smp_ready,
    output logic [SBITS-1:0]   smp_data,
    output logic               busy,
    output logic               done,
    output logic [15:0]        reject_cnt
);
    localparam int unsigned    CW = $clog2(DEPTH) + 1;
    localparam logic [SBITS:0] QL = (SBITS+1)'(Q);

    state_e         state_q, state_d;
    logic [15:0]    n_q, n_d, acc_q, acc_d, rej_q, rej_d;
    logic           inflight_q, inflight_d;
    logic           done_q, done_d;
    logic [SBITS-1:0] cand;
    logic           cand_hit, fifo_push;
    logic [CW-1:0]  fifo_count;
    logic           fifo_empty, fifo_full;
    logic           unused_upper;

    assign cand         = rand_num[SBITS-1:0];
    assign unused_upper = ^rand_num[31:SBITS];
    assign cand_hit     = inflight_q && ({1'b0, cand} < QL);
    assign fifo_push    = cand_hit && !fifo_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && (num_samples != '0)) state_d = RUN;
            RUN:     if (acc_q == n_q)                 state_d = DRAIN;
            DRAIN:   if (fifo_empty)                   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // At most one request outstanding; space is reserved for it before asking.
    always_comb begin
        busy    = (state_q != IDLE);
        rand_en = 1'b0;
        if (state_q == RUN) begin
            rand_en = (({1'b0, acc_q} + 17'(inflight_q)) < {1'b0, n_q}) &&
                      ((fifo_count + CW'(inflight_q)) < CW'(DEPTH));
        end
    end

    always_comb begin
        n_d        = n_q;
        acc_d      = acc_q;
        rej_d      = rej_q;
        inflight_d = rand_en;
        done_d     = 1'b0;
        if ((state_q == IDLE) && start) begin
            if (num_samples == '0) begin
                done_d = 1'b1;
            end else begin
                n_d   = num_samples;
                acc_d = '0;
                rej_d = '0;
            end
        end
        if (fifo_push) begin
            acc_d = acc_q + 16'd1;
        end else if (inflight_q && !cand_hit && (rej_q != '1)) begin
            rej_d = rej_q + 16'd1;
        end
        if ((state_q == DRAIN) && fifo_empty) done_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q        <= '0;
            acc_q      <= '0;
            rej_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            n_q        <= n_d;
            acc_q      <= acc_d;
            rej_q      <= rej_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    sample_fifo #(
        .DEPTH (DEPTH),
        .W     (SBITS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (cand),
        .pop   (smp_ready),
        .rdata (smp_data),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign smp_valid  = !fifo_empty;
    assign done       = done_q;
    assign reject_cnt = rej_q;

endmodule

// File: tb/tb_rand_reject_sampler.sv
// Directed bench for rand_reject_sampler with a stub random source and an output logger.
module tb_rand_reject_sampler;

    localparam int unsigned QV = 8380417;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [15:0]        num_samples;
    logic               rand_en;
    logic signed [31:0] rand_num;
    logic               smp_valid;
    logic               smp_ready;
    logic [22:0]        smp_data;
    logic               busy;
    logic               done;
    logic [15:0]        reject_cnt;

    logic [31:0] src [0:15];
    int          src_idx;
    bit          en_seen;
    logic [22:0] outq [$];
    int          done_cnt, en_cnt;
    int          n_checks, n_fail;

    always #5 clk = ~clk;

    rand_reject_sampler #(
        .DEPTH (4),
        .Q     (8380417),
        .SBITS (23)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_samples (num_samples),
        .rand_en     (rand_en),
        .rand_num    (rand_num),
        .smp_valid   (smp_valid),
        .smp_ready   (smp_ready),
        .smp_data    (smp_data),
        .busy        (busy),
        .done        (done),
        .reject_cnt  (reject_cnt)
    );

    // Mid-cycle monitor: logs pops, done pulses and request cycles.
    always @(negedge clk) begin
        en_seen = rand_en;
        if (smp_valid && smp_ready) outq.push_back(smp_data);
        if (done) done_cnt++;
        if (rand_en) en_cnt++;
    end

    // Stub source: a new word appears the cycle after each request.
    always @(posedge clk) begin
        #1;
        if (en_seen) begin
            rand_num = (src_idx < 16) ? src[src_idx] : 32'd0;
            src_idx++;
        end
    end

    task automatic cycles(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] n);
        @(posedge clk); #1;
        start = 1'b1;
        num_samples = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic clear_log();
        outq.delete();
        done_cnt = 0;
        en_cnt   = 0;
        src_idx  = 0;
        for (int unsigned i = 0; i < 16; i++) src[i] = 32'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; num_samples = '0; smp_ready = 1'b0; rand_num = '0;
        clear_log();
        cycles(3);
        n_checks++; if (rand_en !== 1'b0) begin n_fail++; $display("FAIL reset_rand_en: got %b expected 0", rand_en); end
        n_checks++; if (smp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_smp_valid: got %b expected 0", smp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (smp_data !== 23'd0) begin n_fail++; $display("FAIL reset_smp_data: got %0d expected 0", smp_data); end
        n_checks++; if (reject_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_reject_cnt: got %0d expected 0", reject_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        clear_log();
        src[0] = 32'd5; src[1] = QV; src[2] = QV - 1;
        smp_ready = 1'b1;
        pulse_start(16'd2);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_first_start_busy: got %b expected 1", busy); end
        cycles(20);
        n_checks++; if (outq.size() != 2) begin n_fail++; $display("FAIL basic_count: got %0d expected 2", outq.size()); end
        if (outq.size() >= 2) begin
            n_checks++; if (outq[0] !== 23'd5) begin n_fail++; $display("FAIL basic_out0: got %0d expected 5", outq[0]); end
            n_checks++; if (outq[1] !== 23'(QV - 1)) begin n_fail++; $display("FAIL basic_out1: got %0d expected %0d", outq[1], QV - 1); end
        end
        n_checks++; if (reject_cnt !== 16'd1) begin n_fail++; $display("FAIL basic_reject_cnt: got %0d expected 1", reject_cnt); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt); end
        n_checks++; if (en_cnt != 3) begin n_fail++; $display("FAIL basic_requests: got %0d expected 3", en_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_upper_bits();
        clear_log();
        src[0] = 32'hFF80_0005;
        pulse_start(16'd1);
        cycles(15);
        n_checks++; if (outq.size() != 1) begin n_fail++; $display("FAIL upper_count: got %0d expected 1", outq.size()); end
        if (outq.size() >= 1) begin
            n_checks++; if (outq[0] !== 23'd5) begin n_fail++; $display("FAIL upper_data: got %0d expected 5", outq[0]); end
        end
        n_checks++; if (reject_cnt !== 16'd0) begin n_fail++; $display("FAIL upper_reject_cnt: got %0d expected 0", reject_cnt); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL upper_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_boundary();
        clear_log();
        src[0] = QV - 1; src[1] = QV; src[2] = 32'h007F_FFFF; src[3] = 32'd0;
        pulse_start(16'd2);
        cycles(20);
        n_checks++; if (outq.size() != 2) begin n_fail++; $display("FAIL bound_count: got %0d expected 2", outq.size()); end
        if (outq.size() >= 2) begin
            n_checks++; if (outq[0] !== 23'(QV - 1)) begin n_fail++; $display("FAIL bound_out0: got %0d expected %0d", outq[0], QV - 1); end
            n_checks++; if (outq[1] !== 23'd0) begin n_fail++; $display("FAIL bound_out1: got %0d expected 0", outq[1]); end
        end
        n_checks++; if (reject_cnt !== 16'd2) begin n_fail++; $display("FAIL bound_reject_cnt: got %0d expected 2", reject_cnt); end
        n_checks++; if (en_cnt != 4) begin n_fail++; $display("FAIL bound_requests: got %0d expected 4", en_cnt); end
    endtask

    task automatic test_backpressure();
        clear_log();
        for (int unsigned i = 0; i < 8; i++) src[i] = 32'd100 + i;
        smp_ready = 1'b0;
        pulse_start(16'd8);
        cycles(15);
        n_checks++; if (en_cnt != 4) begin n_fail++; $display("FAIL bp_requests_full: got %0d expected 4", en_cnt); end
        n_checks++; if (rand_en !== 1'b0) begin n_fail++; $display("FAIL bp_rand_en_low: got %b expected 0", rand_en); end
        n_checks++; if (smp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", smp_valid); end
        n_checks++; if (smp_data !== 23'd100) begin n_fail++; $display("FAIL bp_head: got %0d expected 100", smp_data); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy: got %b expected 1", busy); end
        cycles(5);
        n_checks++; if (smp_data !== 23'd100) begin n_fail++; $display("FAIL bp_head_stable: got %0d expected 100", smp_data); end
        n_checks++; if (en_cnt != 4) begin n_fail++; $display("FAIL bp_requests_hold: got %0d expected 4", en_cnt); end
        smp_ready = 1'b1;
        cycles(30);
        n_checks++; if (outq.size() != 8) begin n_fail++; $display("FAIL bp_count: got %0d expected 8", outq.size()); end
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < outq.size()) begin
                n_checks++;
                if (outq[i] !== 23'(100 + i)) begin n_fail++; $display("FAIL bp_order[%0d]: got %0d expected %0d", i, outq[i], 100 + i); end
            end
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done_pulses: got %0d expected 1", done_cnt); end
        n_checks++; if (en_cnt != 8) begin n_fail++; $display("FAIL bp_requests_total: got %0d expected 8", en_cnt); end
    endtask

    task automatic test_zero();
        clear_log();
        pulse_start(16'd0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b expected 1", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b expected 0", busy); end
        cycles(1);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_single: got %b expected 0", done); end
        cycles(3);
        n_checks++; if (en_cnt != 0) begin n_fail++; $display("FAIL zero_requests: got %0d expected 0", en_cnt); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL zero_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_ignore_start();
        clear_log();
        for (int unsigned i = 0; i < 7; i++) src[i] = 32'd20 + i;
        smp_ready = 1'b1;
        pulse_start(16'd4);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy: got %b expected 1", busy); end
        pulse_start(16'd3);
        cycles(25);
        n_checks++; if (outq.size() != 4) begin n_fail++; $display("FAIL ign_count: got %0d expected 4", outq.size()); end
        for (int unsigned i = 0; i < 4; i++) begin
            if (i < outq.size()) begin
                n_checks++;
                if (outq[i] !== 23'(20 + i)) begin n_fail++; $display("FAIL ign_order[%0d]: got %0d expected %0d", i, outq[i], 20 + i); end
            end
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL ign_done_pulses: got %0d expected 1", done_cnt); end
        n_checks++; if (en_cnt != 4) begin n_fail++; $display("FAIL ign_requests: got %0d expected 4", en_cnt); end
    endtask

    task automatic test_reset_mid_run();
        clear_log();
        src[0] = QV;
        for (int unsigned i = 1; i < 9; i++) src[i] = 32'd9 + i;
        smp_ready = 1'b0;
        pulse_start(16'd8);
        cycles(4);
        n_checks++; if (smp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b expected 1", smp_valid); end
        n_checks++; if (reject_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_pre_reject: got %0d expected 1", reject_cnt); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (smp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", smp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", busy); end
        n_checks++; if (reject_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_reject: got %0d expected 0", reject_cnt); end
        n_checks++; if (rand_en !== 1'b0) begin n_fail++; $display("FAIL mid_rand_en: got %b expected 0", rand_en); end
        n_checks++; if (smp_data !== 23'd0) begin n_fail++; $display("FAIL mid_smp_data: got %0d expected 0", smp_data); end
        cycles(2);
        rst_n = 1'b1;
        cycles(3);
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL mid_no_done: got %0d expected 0", done_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle_after: got %b expected 0", busy); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_upper_bits();
        test_boundary();
        test_backpressure();
        test_zero();
        test_ignore_start();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
